// File: rtl/bus_mux8_1_pkg.sv
// rtl/bus_mux8_1_pkg.sv - select-width constants for the 8:1 bus multiplexer slice
//
// Constants only. WIDTH stays a per-instance parameter on each module, so no
// bus types are defined here.
package bus_mux8_1_pkg;

    // Top-level fan-in and select width.
    localparam int NUM_BUSES = 8;
    localparam int SEL_W     = 3;

    // Each half of the top is a 4:1 stage driven by the low select bits.
    localparam int QUAD_BUSES = 4;
    localparam int QUAD_SEL_W = 2;

endpackage : bus_mux8_1_pkg

// File: rtl/bus_mux4_1.sv
// rtl/bus_mux4_1.sv - combinational 4:1 bus multiplexer
//
// Ports:
//   in  [3:0][WIDTH-1:0]  four data buses, index equals select code
//   sel [1:0]             select code 0..3
//   out [WIDTH-1:0]       in[sel], purely combinational
module bus_mux4_1
    import bus_mux8_1_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [QUAD_BUSES-1:0][WIDTH-1:0] in,
    input  logic [QUAD_SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]                 out
);

    // Direct indexing rather than a case statement: an unknown select
    // yields an unknown bus in simulation instead of silently picking a
    // default branch.
    assign out = in[sel];

endmodule : bus_mux4_1

// File: rtl/bus_mux8_1.sv
// rtl/bus_mux8_1.sv - 8:1 bus multiplexer with combinational and registered outputs
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-high reset, clears out_q only
//   in  [7:0][WIDTH-1:0] eight data buses, index equals select code
//   sel [2:0]            select code 0..7
//   out [WIDTH-1:0]      in[sel], combinational, unaffected by reset
//   out_q [WIDTH-1:0]    out registered on each rising edge of clk
module bus_mux8_1
    import bus_mux8_1_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_BUSES-1:0][WIDTH-1:0] in,
    input  logic [SEL_W-1:0]               sel,
    output logic [WIDTH-1:0]               out,
    output logic [WIDTH-1:0]               out_q
);

    // half[0] carries the choice among in[3:0], half[1] among in[7:4].
    logic [1:0][WIDTH-1:0] half;

    bus_mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux_lo (
        .in  (in[3:0]),
        .sel (sel[QUAD_SEL_W-1:0]),
        .out (half[0])
    );

    bus_mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux_hi (
        .in  (in[7:4]),
        .sel (sel[QUAD_SEL_W-1:0]),
        .out (half[1])
    );

    // Final 2:1 stage on the top select bit; indexing keeps an unknown
    // sel[2] visible as an unknown bus in simulation.
    assign out = half[sel[SEL_W-1]];

    // The only state in the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule : bus_mux8_1

// File: tb/tb_bus_mux8_1.sv
// tb/tb_bus_mux8_1.sv - self-checking bench for bus_mux8_1 and bus_mux4_1
module tb_bus_mux8_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [2:0]         sel;
    logic [7:0][11:0]   in12;
    logic [11:0]        out12;
    logic [11:0]        outq12;
    logic [7:0][63:0]   in64;
    logic [63:0]        out64;
    logic [63:0]        outq64;
    logic [3:0][11:0]   in4;
    logic [1:0]         sel4;
    logic [11:0]        out4;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: the eight bus values and the expected registered output.
    logic [11:0] ref_bus [8];
    logic [11:0] ref_q;

    bus_mux8_1 #(.WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in12),
        .sel   (sel),
        .out   (out12),
        .out_q (outq12)
    );

    bus_mux8_1 #(.WIDTH(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .in    (in64),
        .sel   (sel),
        .out   (out64),
        .out_q (outq64)
    );

    bus_mux4_1 #(.WIDTH(12)) dut4 (
        .in  (in4),
        .sel (sel4),
        .out (out4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic load_bus();
        for (int k = 0; k < 8; k++) begin
            in12[k] = ref_bus[k];
            in64[k] = 64'h1 << (k * 8);
        end
        for (int k = 0; k < 4; k++) in4[k] = ref_bus[k];
    endtask

    // Drive sel/reset at the falling edge, check the combinational outputs and
    // that out_q still holds, then check out_q after the next rising edge.
    task automatic step(input logic [2:0] s, input logic r, input string tag);
        logic [63:0] onehot;
        @(negedge clk);
        sel   = s;
        sel4  = s[1:0];
        reset = r;
        onehot = 64'h1 << (int'(s) * 8);
        #1;
        chk({tag, "_out"},    {52'h0, out12},  {52'h0, ref_bus[s]});
        chk({tag, "_out64"},  out64,           onehot);
        chk({tag, "_mux4"},   {52'h0, out4},   {52'h0, ref_bus[s[1:0]]});
        chk({tag, "_qhold"},  {52'h0, outq12}, {52'h0, ref_q});
        @(posedge clk);
        ref_q = r ? 12'h000 : ref_bus[s];
        #1;
        chk({tag, "_outq"},   {52'h0, outq12}, {52'h0, ref_q});
        chk({tag, "_outpost"}, {52'h0, out12}, {52'h0, ref_bus[s]});
    endtask

    initial begin
        ref_bus[0] = 12'h760; ref_bus[1] = 12'h5F1;
        ref_bus[2] = 12'hC0E; ref_bus[3] = 12'hC7C;
        ref_bus[4] = 12'hC5A; ref_bus[5] = 12'h93E;
        ref_bus[6] = 12'h64A; ref_bus[7] = 12'h87E;
        ref_q = 12'h000;
        reset = 1'b1;
        sel   = 3'd3;
        sel4  = 2'd3;
        load_bus();
        @(posedge clk);
        @(posedge clk);

        // Reset held with sel 3, then release.
        step(3'd3, 1'b1, "rst0");
        step(3'd3, 1'b1, "rst1");
        step(3'd3, 1'b0, "rel");

        // Directed sweep with the reference values.
        for (int s = 0; s < 8; s++) step(3'(s), 1'b0, "sweep");

        // Same sweep with every bus inverted.
        for (int k = 0; k < 8; k++) ref_bus[k] = ~ref_bus[k];
        load_bus();
        for (int s = 0; s < 8; s++) step(3'(s), 1'b0, "inv");
        for (int k = 0; k < 8; k++) ref_bus[k] = ~ref_bus[k];
        load_bus();

        // Select moves 2 -> 6 between edges; out_q must hold C0E until the edge.
        step(3'd2, 1'b0, "sel2");
        step(3'd6, 1'b0, "sel6");

        // Reset asserted mid-sweep at sel 4.
        step(3'd3, 1'b0, "mid3");
        step(3'd4, 1'b1, "midrst");
        step(3'd5, 1'b0, "midrel");

        // Randomized buses, selects and occasional reset.
        for (int i = 0; i < 48; i++) begin
            for (int k = 0; k < 8; k++) ref_bus[k] = 12'($urandom_range(0, 4095));
            load_bus();
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_bus_mux8_1
